// File: rtl/spill_fill_engine.sv
// spill_fill_engine
//   Restores spilled registers from the LDS spill buffer into the register
//   file, then releases the spill slots back to the allocator.
//
//   One fill command is accepted at a time (fill_ready high only in IDLE).
//   Reads go out as rd_addr = base+issued with at most MAX_OUT outstanding.
//   In-order responses become registered RF writes to preg+received.
//   A one-cycle RETIRE state pulses free_req/free_n and done_valid/done_wid.
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     fill_valid/ready/wid/base/n/preg  fill command handshake and fields
//     rd_valid/ready/addr           spill-buffer read request
//     rsp_valid/data                in-order read return
//     rf_wr_en/addr/data            register-file write port
//     free_req/free_n               slot release toward the allocator
//     done_valid/done_wid           completion report
//     busy                          engine not idle
//
//   Optional feature, enabled by defining SPILL_FILL_STATS_EN:
//     stat_fills[31:0]  completed fills (saturating)
//     stat_words[31:0]  register-file writes (saturating)
module spill_fill_engine #(
  parameter int SLOTS     = 256,
  parameter int ADDR_W    = $clog2(SLOTS),
  parameter int PHYS_REGS = 1024,
  parameter int PREG_W    = $clog2(PHYS_REGS),
  parameter int WID_W     = 5,
  parameter int DATA_W    = 32,
  parameter int MAX_OUT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [WID_W-1:0]  fill_wid,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [7:0]        fill_n,
  input  logic [PREG_W-1:0] fill_preg,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              rf_wr_en,
  output logic [PREG_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              free_req,
  output logic [7:0]        free_n,
  output logic              done_valid,
  output logic [WID_W-1:0]  done_wid,
  output logic              busy
`ifdef SPILL_FILL_STATS_EN
  ,
  output logic [31:0]       stat_fills,
  output logic [31:0]       stat_words
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RETIRE} state_t;

  state_t              r_state, w_next;
  logic [WID_W-1:0]    r_wid;
  logic [ADDR_W-1:0]   r_base;
  logic [7:0]          r_n;
  logic [PREG_W-1:0]   r_preg;
  logic [7:0]          r_issued;
  logic [7:0]          r_received;
  logic [3:0]          r_outstanding;
  logic                r_wr_en;
  logic [PREG_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;

  logic w_accept, w_rd_ok, w_rd_fire, w_rsp_take, w_last_issue;

  assign w_accept     = fill_valid && (r_state == S_IDLE);
  assign w_rd_ok      = (r_state == S_ISSUE) && (r_issued < r_n) &&
                        (r_outstanding < 4'(MAX_OUT));
  assign w_rd_fire    = w_rd_ok && rd_ready;
  // Responses with nothing outstanding (e.g. stragglers after reset) are dropped.
  assign w_rsp_take   = rsp_valid && (r_outstanding != '0) &&
                        ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  assign w_last_issue = ({1'b0, r_issued} + 9'd1) == {1'b0, r_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    fill_ready = 1'b0;
    rd_valid   = 1'b0;
    rd_addr    = '0;
    free_req   = 1'b0;
    free_n     = '0;
    done_valid = 1'b0;
    done_wid   = '0;
    busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        fill_ready = 1'b1;
        busy       = 1'b0;
        if (w_accept) w_next = (fill_n == 8'd0) ? S_RETIRE : S_ISSUE;
      end
      S_ISSUE: begin
        rd_valid = w_rd_ok;
        if (w_rd_ok) rd_addr = r_base + ADDR_W'(r_issued);
        if (w_rd_fire && w_last_issue) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // received reaches n when the last write is registered, so RETIRE
        // lands in the cycle after that write is visible.
        if ((r_received == r_n) && (r_outstanding == '0)) w_next = S_RETIRE;
      end
      S_RETIRE: begin
        free_req   = (r_n != 8'd0);
        free_n     = r_n;
        done_valid = 1'b1;
        done_wid   = r_wid;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wid         <= '0;
      r_base        <= '0;
      r_n           <= '0;
      r_preg        <= '0;
      r_issued      <= '0;
      r_received    <= '0;
      r_outstanding <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
    end else begin
      r_wr_en <= w_rsp_take;
      if (w_accept) begin
        r_wid         <= fill_wid;
        r_base        <= fill_base;
        r_n           <= fill_n;
        r_preg        <= fill_preg;
        r_issued      <= '0;
        r_received    <= '0;
        r_outstanding <= '0;
      end else begin
        if (w_rd_fire) r_issued <= r_issued + 8'd1;
        if (w_rsp_take) begin
          r_received <= r_received + 8'd1;
          r_wr_addr  <= r_preg + PREG_W'(r_received);
          r_wr_data  <= rsp_data;
        end
        // Simultaneous issue and return leaves the count unchanged.
        if (w_rd_fire && !w_rsp_take)      r_outstanding <= r_outstanding + 4'd1;
        else if (!w_rd_fire && w_rsp_take) r_outstanding <= r_outstanding - 4'd1;
      end
    end
  end

  assign rf_wr_en   = r_wr_en;
  assign rf_wr_addr = r_wr_addr;
  assign rf_wr_data = r_wr_data;

`ifdef SPILL_FILL_STATS_EN
  logic [31:0] r_stat_fills, r_stat_words;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_fills <= '0;
      r_stat_words <= '0;
    end else begin
      if ((r_state == S_RETIRE) && (r_stat_fills != '1)) r_stat_fills <= r_stat_fills + 32'd1;
      if (r_wr_en && (r_stat_words != '1))               r_stat_words <= r_stat_words + 32'd1;
    end
  end

  assign stat_fills = r_stat_fills;
  assign stat_words = r_stat_words;
`endif

endmodule
